// File: rtl/ram_scan_reader.sv
// Read-side sequencer for the 32x4 RAM: sweeps or single-steps the read address and
// re-aligns each returned word with its address for the HEX display stage.
module ram_scan_reader #(
   parameter int ADDR_W      = 5,
   parameter int DATA_W      = 4,
   parameter int TICK_CYCLES = 50_000_000,
   parameter int RD_LATENCY  = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              hold,
   input  logic              step,
   output logic [ADDR_W-1:0] rdaddress,
   input  logic [DATA_W-1:0] q,
   output logic [ADDR_W-1:0] disp_addr,
   output logic [DATA_W-1:0] disp_data,
   output logic              disp_valid,
   output logic              advance
);

   localparam int              PRE_W    = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_CYCLES - 1);

   typedef enum logic {
      RUN  = 1'b0,
      HOLD = 1'b1
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [PRE_W-1:0]  pre;
   logic [PRE_W-1:0]  pre_next;
   logic              adv;

   logic              hold_m;
   logic              hold_s;
   logic              step_m;
   logic              step_s;
   logic              step_d;
   logic              step_rise;

   logic [ADDR_W-1:0] apipe [RD_LATENCY];
   logic              vpipe [RD_LATENCY];

   // Both key inputs arrive from the board asynchronously; two flops each before use.
   always_ff @(posedge clock) begin
      if (reset) begin
         hold_m <= 1'b0;
         hold_s <= 1'b0;
         step_m <= 1'b0;
         step_s <= 1'b0;
         step_d <= 1'b0;
      end else begin
         hold_m <= hold;
         hold_s <= hold_m;
         step_m <= step;
         step_s <= step_m;
         step_d <= step_s;
      end
   end

   assign step_rise = step_s & ~step_d;

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= RUN;
         pre   <= '0;
      end else begin
         state <= state_next;
         pre   <= pre_next;
      end
   end

   // hold_s wins over a coinciding terminal count, and a step edge only counts while
   // the freeze is both registered and still requested.
   always_comb begin
      state_next = state;
      pre_next   = pre;
      adv        = 1'b0;
      case (state)
         RUN: begin
            if (hold_s) begin
               state_next = HOLD;
               pre_next   = '0;
            end else begin
               adv      = (pre == PRE_LAST);
               pre_next = adv ? '0 : pre + PRE_W'(1);
            end
         end
         HOLD: begin
            pre_next = '0;
            if (!hold_s) begin
               state_next = RUN;
            end else begin
               adv = step_rise;
            end
         end
         default: begin
            state_next = RUN;
            pre_next   = '0;
         end
      endcase
   end

   assign advance = adv;

   always_ff @(posedge clock) begin
      if (reset) begin
         rdaddress <= '0;
      end else if (adv) begin
         rdaddress <= rdaddress + ADDR_W'(1);
      end
   end

   // The address and a validity flag travel alongside the RAM read so the display
   // register captures q together with the address that produced it.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < RD_LATENCY; i++) begin
            apipe[i] <= '0;
            vpipe[i] <= 1'b0;
         end
         disp_addr  <= '0;
         disp_data  <= '0;
         disp_valid <= 1'b0;
      end else begin
         apipe[0] <= rdaddress;
         vpipe[0] <= 1'b1;
         for (int i = 1; i < RD_LATENCY; i++) begin
            apipe[i] <= apipe[i-1];
            vpipe[i] <= vpipe[i-1];
         end
         disp_addr  <= apipe[RD_LATENCY-1];
         disp_data  <= q;
         disp_valid <= vpipe[RD_LATENCY-1];
      end
   end

endmodule
